// File: rtl/lsc_pkg.sv
// Shared widths, packing offsets, FSM states and constants
// for the local store sequencer.
package lsc_pkg;

  function automatic int ctrl_w(input int depth, input int a);
    return 8 + 3 * depth + 2 * a;
  endfunction

  function automatic int inst_w(input int depth, input int a,
                                input int r);
    return r + ctrl_w(depth, a);
  endfunction

  function automatic int pe_w(input int depth, input int a);
    return 2 * depth + 2 * a;
  endfunction

  function automatic int init_lsb(input int depth, input int a);
    return pe_w(depth, a);
  endfunction

  function automatic int ctl_lsb(input int depth, input int a);
    return pe_w(depth, a) + depth;
  endfunction

  function automatic int rep_lsb(input int depth, input int a);
    return ctrl_w(depth, a);
  endfunction

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } lsc_state_e;

  localparam logic [7:0] LSC_NOP = 8'h00;

endpackage

// File: rtl/local_store_sequencer_fifo.sv
// Small synchronous FIFO holding packed instructions.
// Head entry is read combinationally.
module inst_fifo #(
  parameter int WIDTH = 36,
  parameter int FD    = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [FD:0]      count_o
);

  localparam logic [FD:0]   FULL = (FD+1)'(2**FD);
  localparam logic [FD:0]   C1   = (FD+1)'(1);
  localparam logic [FD-1:0] P1   = FD'(1);

  logic [WIDTH-1:0] mem_q [2**FD];
  logic [FD-1:0]    wr_q, rd_q;
  logic [FD:0]      cnt_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (cnt_q != FULL);
  assign do_pop  = pop_i && (cnt_q != '0);
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Storage write; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + P1;
      if (do_pop)  rd_q <= rd_q + P1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + C1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - C1;
    end
  end

endmodule

// File: rtl/local_store_sequencer.sv
// Streams buffered control instructions into the local store
// controller, repeating each for its programmed cycle count.
module local_store_sequencer
  import lsc_pkg::*;
#(
  parameter int depth = 2,
  parameter int A     = 7,
  parameter int R     = 8,
  parameter int FD    = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     instValid,
  output logic                     instReady,
  input  logic [inst_w(depth,A,R)-1:0] instData,
  input  logic                     hold,
  output logic [7:0]               controlSignal,
  output logic [depth-1:0]         initSettings,
  output logic [pe_w(depth,A)-1:0] peConfig,
  output logic                     issueValid,
  output logic                     lastIssue,
  output logic                     busy,
  output logic [FD:0]              fifoCount
);

  localparam int IW  = inst_w(depth, A, R);
  localparam int PW  = pe_w(depth, A);
  localparam int ILS = init_lsb(depth, A);
  localparam int CLS = ctl_lsb(depth, A);
  localparam int RLS = rep_lsb(depth, A);

  localparam logic [FD:0]  FULL = (FD+1)'(2**FD);
  localparam logic [FD:0]  C1   = (FD+1)'(1);
  localparam logic [R-1:0] N1   = R'(1);

  lsc_state_e       state_q, state_d;
  logic [R-1:0]     cnt_q;
  logic [7:0]       cur_ctl_q;
  logic [7:0]       ctl_q;
  logic [depth-1:0] ini_q;
  logic [PW-1:0]    pe_q;
  logic             valid_q, last_q, busy_q;

  logic [IW-1:0]    head;
  logic [FD:0]      fcnt, fcnt_d;
  logic             push, load, step, go_idle, busy_d;

  assign instReady = (fcnt < FULL);
  assign push      = instValid && instReady;

  inst_fifo #(
    .WIDTH (IW),
    .FD    (FD)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .pop_i   (load),
    .din_i   (instData),
    .dout_o  (head),
    .count_o (fcnt)
  );

  // Issue decisions for the coming cycle.
  always_comb begin
    load    = !hold && (fcnt != '0) &&
              ((state_q == S_IDLE) || (cnt_q == '0));
    step    = (state_q == S_ISSUE) && !hold && (cnt_q != '0);
    go_idle = (state_q == S_ISSUE) && !hold &&
              (cnt_q == '0) && (fcnt == '0);
    state_d = state_q;
    if (load)         state_d = S_ISSUE;
    else if (go_idle) state_d = S_IDLE;
    fcnt_d = fcnt;
    if (push && !load)      fcnt_d = fcnt + C1;
    else if (!push && load) fcnt_d = fcnt - C1;
    busy_d = (state_d == S_ISSUE) || (fcnt_d != '0);
  end

  // Sequencer FSM, repeat counter and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cur_ctl_q <= LSC_NOP;
      ctl_q     <= LSC_NOP;
      ini_q     <= '0;
      pe_q      <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      if (load) begin
        cnt_q     <= head[RLS +: R];
        cur_ctl_q <= head[CLS +: 8];
        ctl_q     <= head[CLS +: 8];
        ini_q     <= head[ILS +: depth];
        pe_q      <= head[0 +: PW];
        valid_q   <= 1'b1;
        last_q    <= (head[RLS +: R] == '0);
      end else if (step) begin
        cnt_q   <= cnt_q - N1;
        ctl_q   <= cur_ctl_q;
        valid_q <= 1'b1;
        last_q  <= (cnt_q == N1);
      end else begin
        ctl_q   <= LSC_NOP;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign controlSignal = ctl_q;
  assign initSettings  = ini_q;
  assign peConfig      = pe_q;
  assign issueValid    = valid_q;
  assign lastIssue     = last_q;
  assign busy          = busy_q;
  assign fifoCount     = fcnt;

endmodule

// File: tb/tb_local_store_sequencer.sv
// Directed bench for local_store_sequencer: issue timing,
// back-to-back, hold, max repeat, reset and full-FIFO cases.
module tb_local_store_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        instValid = 1'b0;
  logic        hold = 1'b0;
  logic [35:0] instData = '0;
  logic        instReady;
  logic [7:0]  controlSignal;
  logic [1:0]  initSettings;
  logic [17:0] peConfig;
  logic        issueValid, lastIssue, busy;
  logic [2:0]  fifoCount;

  int checks = 0;
  int failures = 0;
  int nv, nl;

  local_store_sequencer #(
    .depth (2), .A (7), .R (8), .FD (2)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .instValid     (instValid),
    .instReady     (instReady),
    .instData      (instData),
    .hold          (hold),
    .controlSignal (controlSignal),
    .initSettings  (initSettings),
    .peConfig      (peConfig),
    .issueValid    (issueValid),
    .lastIssue     (lastIssue),
    .busy          (busy),
    .fifoCount     (fifoCount)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] mk(input logic [7:0] rep,
                                     input logic [7:0] ctl,
                                     input logic [1:0] ini,
                                     input logic [17:0] pe);
    return {rep, ctl, ini, pe};
  endfunction

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic push(input logic [35:0] d);
    instValid = 1'b1;
    instData  = d;
    step();
    instValid = 1'b0;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_ready"}, 32'(instReady), 32'd1);
    chk({p, "_valid"}, 32'(issueValid), 32'd0);
    chk({p, "_last"}, 32'(lastIssue), 32'd0);
    chk({p, "_busy"}, 32'(busy), 32'd0);
    chk({p, "_count"}, 32'(fifoCount), 32'd0);
    chk({p, "_ctrl"}, 32'(controlSignal), 32'd0);
    chk({p, "_init"}, 32'(initSettings), 32'd0);
    chk({p, "_pe"}, 32'(peConfig), 32'd0);
  endtask

  initial begin
    @(negedge CLK);
    step();
    step();
    chk_reset("rst");
    RST = 1'b0;

    // basic issue: repeat=2 -> 3 live cycles
    push(mk(8'd2, 8'h08, 2'b01, 18'h12345));
    chk("basic_cnt", 32'(fifoCount), 32'd1);
    chk("basic_pre", 32'(issueValid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("basic_valid", 32'(issueValid), 32'(i < 3));
      chk("basic_ctrl", 32'(controlSignal), (i < 3) ? 32'h08 : 32'h0);
      chk("basic_last", 32'(lastIssue), 32'(i == 2));
      chk("basic_busy", 32'(busy), 32'(i < 3));
    end
    chk("basic_pe", 32'(peConfig), 32'h12345);
    chk("basic_init", 32'(initSettings), 32'd1);

    // back-to-back: fill under hold, refuse 5th, drain
    hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      push(mk(8'd0, 8'(k), 2'b00, 18'(k)));
      chk("b2b_fill", 32'(fifoCount), 32'(k));
    end
    chk("b2b_ready", 32'(instReady), 32'd0);
    push(mk(8'd0, 8'h05, 2'b00, 18'h5));
    chk("b2b_refuse", 32'(fifoCount), 32'd4);
    hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("b2b_ctrl", 32'(controlSignal), (i < 4) ? 32'(i + 1) : 32'd0);
      chk("b2b_valid", 32'(issueValid), 32'(i < 4));
      chk("b2b_last", 32'(lastIssue), 32'(i < 4));
      if (i == 0) chk("b2b_cnt", 32'(fifoCount), 32'd3);
    end

    // push/pop at full
    hold = 1'b1;
    for (int k = 0; k < 4; k++)
      push(mk(8'd0, 8'(8'h11 + k), 2'b00, 18'(k)));
    instValid = 1'b1;
    instData  = mk(8'd0, 8'h15, 2'b00, 18'h0);
    hold = 1'b0;
    step();
    chk("full_cnt", 32'(fifoCount), 32'd3);
    chk("full_ready", 32'(instReady), 32'd1);
    chk("full_ctrl0", 32'(controlSignal), 32'h11);
    step();
    instValid = 1'b0;
    chk("full_cnt2", 32'(fifoCount), 32'd3);
    chk("full_ctrl1", 32'(controlSignal), 32'h12);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("full_seq", 32'(controlSignal),
          (i < 3) ? 32'(8'h13 + i) : 32'd0);
    end

    // hold for 5 cycles inside a repeat=3 instruction
    push(mk(8'd3, 8'h21, 2'b10, 18'h3ABCD));
    step();
    chk("hold_first", 32'(issueValid), 32'd1);
    nv = int'(issueValid);
    nl = int'(lastIssue);
    for (int j = 0; j < 12; j++) begin
      hold = (j < 5);
      step();
      nv += int'(issueValid);
      nl += int'(lastIssue);
      if (j < 5) begin
        chk("hold_ctrl", 32'(controlSignal), 32'd0);
        chk("hold_valid", 32'(issueValid), 32'd0);
        chk("hold_pe", 32'(peConfig), 32'h3ABCD);
      end
    end
    hold = 1'b0;
    chk("hold_nvalid", 32'(nv), 32'd4);
    chk("hold_nlast", 32'(nl), 32'd1);

    // maximum repeat
    push(mk(8'hFF, 8'h33, 2'b01, 18'h5));
    nv = 0;
    nl = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      nv += int'(issueValid);
      nl += int'(lastIssue);
    end
    chk("max_nvalid", 32'(nv), 32'd256);
    chk("max_nlast", 32'(nl), 32'd1);
    chk("max_busy", 32'(busy), 32'd0);

    // reset mid-operation with two queued entries
    push(mk(8'd5, 8'h41, 2'b11, 18'h2AAAA));
    step();
    push(mk(8'd0, 8'h42, 2'b00, 18'h1));
    push(mk(8'd0, 8'h43, 2'b00, 18'h2));
    chk("mid_cnt", 32'(fifoCount), 32'd2);
    chk("mid_valid", 32'(issueValid), 32'd1);
    RST = 1'b1;
    step();
    chk_reset("midrst");
    RST = 1'b0;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      nv += int'(issueValid);
    end
    chk("post_nvalid", 32'(nv), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
